if_fetch: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. It generates the PC, runs the single-outstanding instruction-bus handshake, and handles branch redirects with delay-slot semantics and exception/ERET flushes. It holds the IF/ID pipeline register whose if_inst feeds the ID decoder. A 1-entry skid buffer absorbs a fetch that completes while ID is stalled.

---
 rtl/ibus_if.sv | 10 +
 rtl/if_fetch.sv | 143 ++++++++++++++
 tb/tb_if_fetch.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibus_if.sv
// Instruction-bus handshake bundle: one request outstanding, completion by ack.
interface ibus_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC generation, single-outstanding ibus handshake,
// delayed-branch redirect, exception/ERET flush, IF/ID register with a
// one-entry skid buffer behind it.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetching; completions land in IF/ID or the skid buffer
// DROP  | a request issued before a flush is still open; its data is
//       | discarded and the old address is held until ack
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  ibus_if.master      ibus,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_addr_err
);

  typedef enum logic {RUN, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] drop_addr;
  logic [31:0] saved_target;
  logic        redirect_pending;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        err_sent;

  logic        req_c;
  logic [31:0] addr_c;
  logic        complete;
  logic        br_take;
  logic        id_free;
  logic        synth_ok;
  logic [31:0] next_fetch_pc;

  assign ibus.req  = req_c;
  assign ibus.addr = addr_c;

  assign complete = (state == RUN) && req_c && ibus.ack;
  assign br_take  = branch_flag && !stall && !flush;
  assign id_free  = !if_valid || !stall;
  // A misaligned pc produces one synthetic AdEL entry, then waits for a flush.
  assign synth_ok = (state == RUN) && (pc[1:0] != 2'b00) && !skid_valid && !err_sent;
  assign next_fetch_pc = br_take          ? branch_target :
                         redirect_pending ? saved_target  :
                                            pc + 32'd4;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state and bus request; no request while reset is asserted.
  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    addr_c    = pc;
    case (state)
      RUN: begin
        req_c  = !rst && !skid_valid && (pc[1:0] == 2'b00);
        addr_c = pc;
        if (flush && req_c && !ibus.ack) state_nxt = DROP;
      end
      DROP: begin
        req_c  = !rst;
        addr_c = drop_addr;
        if (ibus.ack) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // PC, redirect bookkeeping, skid buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc               <= RESET_PC;
      drop_addr        <= 32'h0;
      saved_target     <= 32'h0;
      redirect_pending <= 1'b0;
      skid_valid       <= 1'b0;
      skid_pc          <= 32'h0;
      skid_inst        <= 32'h0;
      err_sent         <= 1'b0;
      if_pc            <= 32'h0;
      if_inst          <= 32'h0;
      if_valid         <= 1'b0;
      if_addr_err      <= 1'b0;
    end else if (flush) begin
      if_valid         <= 1'b0;
      skid_valid       <= 1'b0;
      redirect_pending <= 1'b0;
      err_sent         <= 1'b0;
      pc               <= flush_pc;
      if ((state == RUN) && req_c && !ibus.ack) drop_addr <= pc;
    end else begin
      if (complete) begin
        pc               <= next_fetch_pc;
        redirect_pending <= 1'b0;
      end else if (br_take) begin
        saved_target     <= branch_target;
        redirect_pending <= 1'b1;
      end

      if (skid_valid && !stall) begin
        if_pc       <= skid_pc;
        if_inst     <= skid_inst;
        if_addr_err <= 1'b0;
        if_valid    <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (complete && id_free) begin
        if_pc       <= pc;
        if_inst     <= ibus.rdata;
        if_addr_err <= 1'b0;
        if_valid    <= 1'b1;
      end else if (complete) begin
        skid_pc    <= pc;
        skid_inst  <= ibus.rdata;
        skid_valid <= 1'b1;
      end else if (synth_ok && id_free) begin
        if_pc       <= pc;
        if_inst     <= 32'h0;
        if_addr_err <= 1'b1;
        if_valid    <= 1'b1;
        err_sent    <= 1'b1;
      end else if (!stall) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by randomized stall, bus
// latency, branch and flush traffic, checked against a program-order model.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branch_flag, flush;
  logic [31:0] branch_target, flush_pc;
  logic [31:0] if_pc, if_inst;
  logic        if_valid, if_addr_err;

  ibus_if ibus ();

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .ibus(ibus), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .flush(flush), .flush_pc(flush_pc),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_addr_err(if_addr_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int delivered = 0;

  // ---------------- reference model: expected delivery stream ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } entry_t;
  entry_t      exp_q[$];
  logic [31:0] next_seq;
  bit          halted;
  entry_t      mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic entry_t make_entry(input logic [31:0] a);
    entry_t e;
    e.pc   = a;
    e.err  = (a[1:0] != 2'b00);
    e.inst = e.err ? 32'h0 : mem_word(a);
    return e;
  endfunction

  function automatic logic [31:0] peek_pc();
    if (exp_q.size() != 0) return exp_q[0].pc;
    return next_seq;
  endfunction

  task automatic model_restart(input logic [31:0] a);
    exp_q.delete();
    exp_q.push_back(make_entry(a));
    halted   = (a[1:0] != 2'b00);
    next_seq = a + 32'd4;
  endtask

  task automatic model_branch(input logic [31:0] p, input logic [31:0] tgt);
    exp_q.delete();
    exp_q.push_back(make_entry(p + 32'd4));
    exp_q.push_back(make_entry(tgt));
    halted   = (tgt[1:0] != 2'b00);
    next_seq = tgt + 32'd4;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, actual=none expected=event", name);
  endtask

  // ---------------- monitor: ID consumes IF/ID when valid and not stalled ----
  always @(negedge clk) begin
    if (!rst && if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        if (halted) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: actual pc=%h expected none", if_pc);
        end else begin
          exp_q.push_back(make_entry(next_seq));
          next_seq = next_seq + 32'd4;
        end
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check32("if_pc", if_pc, mon_e.pc);
        check32("if_inst", if_inst, mon_e.inst);
        check32("if_addr_err", {31'h0, if_addr_err}, {31'h0, mon_e.err});
        delivered++;
      end
    end
  end

  // ---------------- bus responder with programmable ack latency --------------
  int          min_delay = 0;
  int          max_delay = 0;
  bit          busy = 0;
  int          wcnt = 0;
  logic [31:0] taddr = 32'h0;
  bit          saw_2000 = 0;

  initial begin
    ibus.ack   = 1'b0;
    ibus.rdata = 32'h0;
  end

  always begin
    @(posedge clk);
    #2;
    if (ibus.req === 1'b1) begin
      if (ibus.addr == 32'h8000_2000) saw_2000 = 1;
      if (!busy) begin
        busy  = 1;
        taddr = ibus.addr;
        wcnt  = $urandom_range(max_delay, min_delay);
      end else begin
        check32("ibus_addr_stable", ibus.addr, taddr);
      end
      if (wcnt == 0) begin
        ibus.ack   = 1'b1;
        ibus.rdata = mem_word(ibus.addr);
        busy       = 0;
      end else begin
        ibus.ack   = 1'b0;
        ibus.rdata = $urandom;
        wcnt--;
      end
    end else begin
      ibus.ack = 1'b0;
      busy     = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit          pend_br = 0, pend_fl = 0;
  logic [31:0] pend_p, pend_tgt, pend_fpc;

  task automatic apply_pending();
    if (pend_fl)      model_restart(pend_fpc);
    else if (pend_br) model_branch(pend_p, pend_tgt);
    pend_fl = 0;
    pend_br = 0;
  endtask

  task automatic put(input logic s, input logic b, input logic [31:0] bt,
                     input logic f, input logic [31:0] fp);
    apply_pending();
    stall         = s;
    branch_flag   = b;
    branch_target = bt;
    flush         = f;
    flush_pc      = fp;
    pend_fl       = f;
    pend_fpc      = fp;
    pend_br       = b && !s && !f;
    pend_p        = peek_pc();
    pend_tgt      = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    pend_br = 0;
    pend_fl = 0;
    rst = 1'b1;
    stall = 1'b0; branch_flag = 1'b0; flush = 1'b0;
    branch_target = 32'h0; flush_pc = 32'h0;
    for (int i = 0; i < n; i++) begin
      tick();
      check32("req_in_reset", {31'h0, ibus.req}, 32'h0);
    end
    model_restart(RESET_PC);
    rst = 1'b0;
  endtask

  task automatic branch_when_ready(input logic [31:0] tgt);
    bit done;
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      put(0, 0, 32'h0, 0, 32'h0);
      #2;
      if (if_valid && exp_q.size() == 0 && !halted) begin
        put(0, 1, tgt, 0, 32'h0);
        done = 1;
      end
      tick();
    end
    if (!done) fail_bound("branch_ready");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      put(0, 0, 32'h0, 0, 32'h0);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] old_addr, rnd, tgt, fp;
    bit found, last_stall, s, b, f;
    int cyc_rand_start;

    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; flush = 1'b0;
    branch_target = 32'h0; flush_pc = 32'h0;
    next_seq = RESET_PC; halted = 0;
    #1;
    do_reset(2);
    check32("reset_if_valid", {31'h0, if_valid}, 32'h0);
    check32("reset_if_pc", if_pc, 32'h0);
    check32("reset_if_inst", if_inst, 32'h0);
    check32("reset_if_addr_err", {31'h0, if_addr_err}, 32'h0);

    // back-to-back fetches with zero-latency ack
    put(0, 0, 0, 0, 0); #2;
    check32("c0_req", {31'h0, ibus.req}, 32'h1);
    check32("c0_addr", ibus.addr, 32'hBFC0_0000);
    tick();
    put(0, 0, 0, 0, 0); #2;
    check32("c1_addr", ibus.addr, 32'hBFC0_0004);
    check32("c1_if_pc", if_pc, 32'hBFC0_0000);
    check32("c1_if_valid", {31'h0, if_valid}, 32'h1);
    tick();
    // stall three cycles: skid captures the next word, request drops
    put(1, 0, 0, 0, 0); #2;
    check32("c2_addr", ibus.addr, 32'hBFC0_0008);
    tick();
    put(1, 0, 0, 0, 0); #2;
    check32("c3_req_skid_full", {31'h0, ibus.req}, 32'h0);
    check32("c3_if_pc_hold", if_pc, 32'hBFC0_0004);
    tick();
    put(1, 0, 0, 0, 0); #2;
    check32("c4_req_skid_full", {31'h0, ibus.req}, 32'h0);
    tick();
    put(0, 0, 0, 0, 0); #2;
    check32("c5_if_pc", if_pc, 32'hBFC0_0004);
    tick();
    // branch resolved while the delay slot is on the bus
    put(0, 1, 32'h8000_1000, 0, 0); #2;
    check32("c6_if_pc", if_pc, 32'hBFC0_0008);
    check32("c6_addr", ibus.addr, 32'hBFC0_000C);
    tick();
    put(0, 0, 0, 0, 0); #2;
    check32("c7_if_pc", if_pc, 32'hBFC0_000C);
    check32("c7_addr", ibus.addr, 32'h8000_1000);
    tick();
    put(0, 0, 0, 0, 0); #2;
    check32("c8_if_pc", if_pc, 32'h8000_1000);
    tick();

    // flush with an outstanding request and slow ack
    min_delay = 3; max_delay = 3;
    found = 0;
    old_addr = 32'h0;
    for (int k = 0; k < 12 && !found; k++) begin
      put(0, 0, 0, 0, 0); #2;
      if (ibus.req && !ibus.ack) begin
        old_addr = ibus.addr;
        put(0, 0, 0, 1, 32'h8000_0180);
        found = 1;
      end
      tick();
    end
    if (!found) fail_bound("flush_setup");
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      put(0, 0, 0, 0, 0); #2;
      if (ibus.req && ibus.addr != old_addr) begin
        check32("post_flush_addr", ibus.addr, 32'h8000_0180);
        found = 1;
      end else begin
        check32("drop_if_valid", {31'h0, if_valid}, 32'h0);
      end
      tick();
    end
    if (!found) fail_bound("post_flush_req");
    min_delay = 0; max_delay = 0;
    found = 0;
    for (int k = 0; k < 15 && !found; k++) begin
      put(0, 0, 0, 0, 0); #2;
      if (if_valid) begin
        check32("flush_target_delivered", if_pc, 32'h8000_0180);
        found = 1;
      end
      tick();
    end
    if (!found) fail_bound("flush_delivery");

    // misaligned branch target: delay slot, one AdEL entry, then silence
    branch_when_ready(32'h8000_1002);
    idle(3);
    for (int k = 0; k < 5; k++) begin
      put(0, 0, 0, 0, 0); #2;
      check32("misaligned_no_req", {31'h0, ibus.req}, 32'h0);
      tick();
    end
    check32("adel_entry_seen", exp_q.size(), 32'h0);
    put(0, 0, 0, 1, 32'h8000_0180);
    tick();
    idle(6);
    check32("resume_after_adel", exp_q.size(), 32'h0);

    // flush and branch in the same cycle: flush wins
    saw_2000 = 0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      put(0, 0, 0, 0, 0); #2;
      if (if_valid) begin
        put(0, 1, 32'h8000_2000, 1, 32'h8000_0180);
        found = 1;
      end
      tick();
    end
    if (!found) fail_bound("flush_branch_setup");
    idle(8);
    check32("branch_lost_to_flush", {31'h0, saw_2000}, 32'h0);
    check32("flush_branch_drain", exp_q.size(), 32'h0);

    // reset while a request is open
    min_delay = 3; max_delay = 3;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      put(0, 0, 0, 0, 0); #2;
      if (ibus.req && !ibus.ack) found = 1;
      tick();
    end
    if (!found) fail_bound("midop_reset_setup");
    do_reset(2);
    min_delay = 0; max_delay = 0;
    idle(6);
    check32("midop_reset_restart", exp_q.size(), 32'h0);

    // randomized traffic
    min_delay = 0; max_delay = 2;
    last_stall = 0;
    cyc_rand_start = delivered;
    for (int i = 0; i < 4000; i++) begin
      put(0, 0, 0, 0, 0);
      s = ($urandom % 4 == 0);
      f = ($urandom % 80 == 0) || (halted && ($urandom % 10 == 0));
      rnd = $urandom;
      fp = {16'h8000, rnd[15:2], 2'b00};
      rnd = $urandom;
      tgt = {16'h8001, rnd[15:2], (($urandom % 12) == 0) ? 2'b10 : 2'b00};
      b = !s && !last_stall && !f && if_valid && exp_q.size() == 0 && !halted &&
          ($urandom % 4 == 0);
      put(s, b, tgt, f, fp);
      tick();
      last_stall = s;
    end
    idle(2);
    checks++;
    if (delivered - cyc_rand_start < 500) begin
      errors++;
      $display("FAIL random_progress: actual=%0d expected>=500", delivered - cyc_rand_start);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
